// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter with a TX FIFO on the MIPS data-memory bus.
// Define UART_TX_PARITY_EN for 8E1 framing (adds a PARITY state and sets STATUS[4]).
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] bus_addr,
   input  logic [31:0] bus_wdata,
   input  logic        bus_we,
   output logic [31:0] bus_rdata,
   output logic        bus_sel,
   output logic        tx,
   output logic        irq
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
   localparam logic PARITY_FLAG = 1'b1;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   localparam logic PARITY_FLAG = 1'b0;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t          state, state_next;
   logic [3:0]      offset;
   logic            in_window;
   logic            wr_txdata, wr_status, wr_baud;
   logic [7:0]      fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   fifo_count;
   logic            fifo_full, fifo_empty;
   logic            push, pop;
   logic [15:0]     baud_div, frame_div, timer;
   logic            timer_done;
   logic [7:0]      shift_reg;
   logic [2:0]      bit_idx;
   logic            ovf, busy;
   logic [4:0]      count_ext;
   logic [31:0]     status_word;
   logic            unused_wdata_bits;
`ifdef UART_TX_PARITY_EN
   logic            parity_bit;
`endif

   assign offset    = bus_addr[3:0];
   assign in_window = bus_addr[31:4] == BASE_ADDR[31:4];
   assign bus_sel   = in_window && (offset == 4'h0 || offset == 4'h4 || offset == 4'h8);
   assign wr_txdata = bus_we && bus_sel && offset == 4'h0;
   assign wr_status = bus_we && bus_sel && offset == 4'h4;
   assign wr_baud   = bus_we && bus_sel && offset == 4'h8;
   assign unused_wdata_bits = ^bus_wdata[31:16];

   assign fifo_full  = fifo_count == DEPTH_C;
   assign fifo_empty = fifo_count == '0;
   assign push       = wr_txdata && !fifo_full;
   assign timer_done = timer == 16'd0;
   assign busy       = state != IDLE;
   assign irq        = fifo_empty && !busy;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= bus_wdata[7:0];
      end
   end

   // A push into a full FIFO is dropped even when the engine pops on the same edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         baud_div <= DEFAULT_DIV;
         ovf      <= 1'b0;
      end else begin
         if (wr_baud) begin
            baud_div <= bus_wdata[15:0];
         end
         if (wr_txdata && fifo_full) begin
            ovf <= 1'b1;
         end else if (wr_status && bus_wdata[3]) begin
            ovf <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      pop        = 1'b0;
      tx         = 1'b1;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               state_next = START;
            end
         end
         START: begin
            tx = 1'b0;
            if (timer_done) begin
               state_next = DATA;
            end
         end
         DATA: begin
            tx = shift_reg[0];
            if (timer_done && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
               state_next = PARITY;
`else
               state_next = STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            tx = parity_bit;
            if (timer_done) begin
               state_next = STOP;
            end
         end
`endif
         STOP: begin
            if (timer_done) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // The divisor is captured per frame so BAUDDIV writes only affect the next frame.
   always_ff @(posedge clk) begin
      if (!rst) begin
         timer     <= '0;
         frame_div <= '0;
         shift_reg <= '0;
         bit_idx   <= '0;
`ifdef UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else if (pop) begin
         shift_reg <= fifo_mem[rd_ptr];
         timer     <= baud_div;
         frame_div <= baud_div;
         bit_idx   <= '0;
`ifdef UART_TX_PARITY_EN
         parity_bit <= ^fifo_mem[rd_ptr];
`endif
      end else if (busy) begin
         if (timer_done) begin
            timer <= frame_div;
            if (state == DATA) begin
               shift_reg <= shift_reg >> 1;
               bit_idx   <= bit_idx + 3'd1;
            end
         end else begin
            timer <= timer - 16'd1;
         end
      end
   end

   assign count_ext   = 5'(fifo_count);
   assign status_word = {19'd0, count_ext, 3'd0, PARITY_FLAG, ovf, busy, fifo_empty, fifo_full};

   always_comb begin
      bus_rdata = '0;
      if (bus_sel) begin
         case (offset)
            4'h4:    bus_rdata = status_word;
            4'h8:    bus_rdata = {16'd0, baud_div};
            default: bus_rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: directed scenarios plus random bus traffic,
// compared against a queue-based model of the FIFO and the expected serial waveform.
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE    = 32'h0000_0100;
   localparam int          DEPTH   = 8;
   localparam int          DEF_DIV = 433;
`ifdef UART_TX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_we;
   logic [31:0] bus_rdata;
   logic        bus_sel;
   logic        tx;
   logic        irq;

   int checks   = 0;
   int failures = 0;

   logic [7:0] m_fifo [$];
   bit         m_line [$];
   bit         m_ovf;
   int         m_div;

   mmio_uart_tx #(
      .BASE_ADDR  (BASE),
      .FIFO_DEPTH (DEPTH),
      .DEFAULT_DIV(16'(DEF_DIV))
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus_addr (bus_addr),
      .bus_wdata(bus_wdata),
      .bus_we   (bus_we),
      .bus_rdata(bus_rdata),
      .bus_sel  (bus_sel),
      .tx       (tx),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   function automatic bit sel_model(input logic [31:0] a);
      return a[31:4] == BASE[31:4] && (a[3:0] == 4'h0 || a[3:0] == 4'h4 || a[3:0] == 4'h8);
   endfunction

   function automatic bit exp_tx();
      return (m_line.size() == 0) ? 1'b1 : m_line[0];
   endfunction

   function automatic logic [31:0] exp_rdata(input logic [31:0] a);
      logic [31:0] s;
      s = '0;
      if (sel_model(a)) begin
         if (a[3:0] == 4'h4) begin
            s[0]    = m_fifo.size() == DEPTH;
            s[1]    = m_fifo.size() == 0;
            s[2]    = m_line.size() != 0;
            s[3]    = m_ovf;
            s[4]    = PAR;
            s[12:8] = 5'(m_fifo.size());
         end else if (a[3:0] == 4'h8) begin
            s = {16'd0, 16'(m_div)};
         end
      end
      return s;
   endfunction

   // The whole frame is laid out as one tx level per clock.
   task automatic build_frame(input logic [7:0] b, input int div);
      for (int k = 0; k <= div; k++) m_line.push_back(1'b0);
      for (int i = 0; i < 8; i++)
         for (int k = 0; k <= div; k++) m_line.push_back(b[i]);
      if (PAR)
         for (int k = 0; k <= div; k++) m_line.push_back(^b);
      for (int k = 0; k <= div; k++) m_line.push_back(1'b1);
   endtask

   task automatic model_step(input bit r, input bit we, input logic [31:0] a, input logic [31:0] d);
      int pre_count;
      bit pre_idle;
      if (!r) begin
         m_fifo.delete();
         m_line.delete();
         m_ovf = 1'b0;
         m_div = DEF_DIV;
      end else begin
         pre_count = m_fifo.size();
         pre_idle  = m_line.size() == 0;
         if (pre_idle && pre_count > 0) begin
            build_frame(m_fifo[0], m_div);
            m_fifo.delete(0);
         end else if (!pre_idle) begin
            m_line.delete(0);
         end
         if (we && sel_model(a)) begin
            case (a[3:0])
               4'h0: if (pre_count < DEPTH) m_fifo.push_back(d[7:0]); else m_ovf = 1'b1;
               4'h4: if (d[3]) m_ovf = 1'b0;
               4'h8: m_div = int'(d[15:0]);
               default: ;
            endcase
         end
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic applyStimulus(input bit r, input bit we, input logic [31:0] a, input logic [31:0] d);
      rst       = r;
      bus_we    = we;
      bus_addr  = a;
      bus_wdata = d;
      @(posedge clk);
      model_step(r, we, a, d);
      #1;
      checkOutput("tx", {31'd0, tx}, {31'd0, exp_tx()});
      checkOutput("irq", {31'd0, irq}, {31'd0, (m_fifo.size() == 0 && m_line.size() == 0)});
      bus_we = 1'b0;
   endtask

   task automatic readCheck(input logic [31:0] a, input string tag);
      bus_we   = 1'b0;
      bus_addr = a;
      #1;
      checkOutput(tag, bus_rdata, exp_rdata(a));
      checkOutput("sel", {31'd0, bus_sel}, {31'd0, sel_model(a)});
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      applyStimulus(1'b1, 1'b1, a, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, BASE + 32'h4, 32'd0);
   endtask

   function automatic logic [31:0] pick_addr();
      logic [31:0] r;
      case ($urandom_range(0, 7))
         0: r = BASE;
         1: r = BASE + 32'h4;
         2: r = BASE + 32'h8;
         3: r = BASE + 32'hC;
         4: r = BASE + 32'h1;
         5: r = BASE + 32'h14;
         6: r = BASE + 32'h4;
         default: r = $urandom();
      endcase
      return r;
   endfunction

   initial begin
      logic [31:0] d;
      rst       = 1'b0;
      bus_we    = 1'b0;
      bus_addr  = '0;
      bus_wdata = '0;

      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
      readCheck(BASE + 32'h4, "rst_status");
      checkOutput("rst_status_const", bus_rdata, 32'h0000_0002);
      readCheck(BASE + 32'h8, "rst_baud");
      checkOutput("rst_baud_const", bus_rdata, 32'd433);
      idle(2);

      wr(BASE + 32'h8, 32'd3);
      wr(BASE, 32'h55);
      readCheck(BASE + 32'h4, "busy_status");
      idle(50);
      readCheck(BASE + 32'h4, "after_55");

      wr(BASE + 32'h8, 32'd0);
      for (int i = 1; i <= 9; i++) wr(BASE, 32'(i));
      readCheck(BASE + 32'h4, "nine_stores");
      wr(BASE, 32'd10);
      readCheck(BASE + 32'h4, "ovf_set");
      wr(BASE + 32'h4, 32'h8);
      readCheck(BASE + 32'h4, "ovf_clear");
      idle(120);

      wr(BASE + 32'h8, 32'd3);
      wr(BASE, 32'hA5);
      wr(BASE, 32'h3C);
      idle(10);
      wr(BASE + 32'h8, 32'd7);
      idle(160);
      readCheck(BASE + 32'h8, "baud7");

      wr(BASE + 32'h8, 32'd3);
      wr(BASE, 32'h11);
      wr(BASE, 32'h22);
      wr(BASE, 32'h33);
      idle(16);
      applyStimulus(1'b0, 1'b0, BASE, 32'd0);
      readCheck(BASE + 32'h4, "midframe_rst");
      idle(40);

      wr(BASE + 32'h8, 32'd1);
      wr(BASE, 32'h07);
      idle(30);
      wr(BASE, 32'h03);
      idle(30);

      for (int n = 0; n < 3000; n++) begin
         d = $urandom();
         case ($urandom_range(0, 9))
            0, 1, 2, 3: wr(BASE, d);
            4: wr(BASE + 32'h4, d);
            5: begin
               d[15:0] = 16'($urandom_range(0, 3));
               wr(BASE + 32'h8, d);
            end
            6: wr(BASE + 32'hC, d);
            7: wr(BASE + 32'h10, d);
            default: idle(1);
         endcase
         readCheck(pick_addr(), "rand_read");
      end
      idle(400);
      readCheck(BASE + 32'h4, "final_status");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
